hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage 64-bit core. Sits beside IF/ID, ID/EX, EX/MEM.

---
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage 64-bit core.
//   It detects load-use hazards and freezes the pipeline while data memory is busy.
//   It flushes the front end on taken branches.
//   It runs a memory-wait FSM with a timeout.
//   It keeps saturating stall and flush performance counters.
//
// Parameters
//   MEM_TIMEOUT  MEM_WAIT cycles without mem_ack before entering ERR (1..255)
//   CNT_W        width of stall_cnt / flush_cnt
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   id_rs1/rs2, id_uses_*    source registers of the instruction in ID
//   ex_load, ex_WRegEn,
//   ex_WReg1                 producer information of the instruction in EX
//   mem_req, mem_ack         data-memory handshake for the instruction in MEM
//   br_taken                 branch/jump in EX resolved taken
//   stall_if/id/mem          hold the corresponding stage registers
//   bubble_ex                zero the ID/EX control fields
//   flush_ifid               invalidate IF/ID
//   mem_timeout_err          sticky memory timeout flag
//   fsm_state                00 RUN, 01 MEM_WAIT, 10 ERR
//   stall_cnt, flush_cnt     saturating performance counters
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_load,
    input  logic             ex_WRegEn,
    input  logic [4:0]       ex_WReg1,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             br_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_mem,
    output logic             bubble_ex,
    output logic             flush_ifid,
    output logic             mem_timeout_err,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic count_stall;

    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_WReg1);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_WReg1);
        load_use = ex_load && ex_WRegEn && (ex_WReg1 != '0) && (rs1_hit || rs2_hit);

        // The ack cycle of MEM_WAIT is not frozen, so the pipeline advances then.
        case (state_q)
            ST_RUN:  freeze = mem_req && !mem_ack;
            ST_WAIT: freeze = !mem_ack;
            ST_ERR:  freeze = 1'b1;
            default: freeze = 1'b0;
        endcase

        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_mem  = 1'b0;
        bubble_ex  = 1'b0;
        flush_ifid = 1'b0;
        if (freeze) begin
            // Any branch or hazard stays parked in its stage until release.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
        end else if (br_taken) begin
            // Redirect squashes the dependent ID instruction, so no stall is needed.
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase

        err_d = err_q || (state_d == ST_ERR);

        count_stall = freeze || (load_use && !br_taken);
        stall_cnt_d = stall_cnt_q;
        if (count_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_ifid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_err = err_q;
    assign fsm_state       = state_q;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl.
// dut uses the default parameters.
// dut_s uses MEM_TIMEOUT=4 and CNT_W=4, which exercises the timeout and counter saturation.
// Each step drives inputs and pushes the expected outputs to a scoreboard queue.
// The entry is popped and compared at the following negedge.
// Control outputs are packed as {stall_if, stall_id, stall_mem, bubble_ex, flush_ifid, err, state}.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic       we;
        logic [4:0] wr;
        logic       req;
        logic       ack;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic        chk_s;
        logic [7:0]  s_ctl;
        logic [31:0] s_scnt;
    } exp_t;

    localparam logic [7:0] C_IDLE = 8'h00;
    localparam logic [7:0] C_FRZR = 8'hE0;
    localparam logic [7:0] C_FRZW = 8'hE1;
    localparam logic [7:0] C_LU   = 8'h90;
    localparam logic [7:0] C_BR   = 8'h18;
    localparam logic [7:0] C_ACK  = 8'h01;
    localparam logic [7:0] C_ACKB = 8'h19;
    localparam logic [7:0] C_ERR  = 8'hE6;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [4:0] id_rs1, id_rs2, ex_WReg1;
    logic       id_uses_rs1, id_uses_rs2, ex_load, ex_WRegEn;
    logic       mem_req, mem_ack, br_taken;

    logic        stall_if, stall_id, stall_mem, bubble_ex, flush_ifid, mem_timeout_err;
    logic [1:0]  fsm_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic       s_stall_if, s_stall_id, s_stall_mem, s_bubble_ex, s_flush_ifid, s_err;
    logic [1:0] s_fsm_state;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    logic [7:0] d_ctl, s_ctl;
    assign d_ctl = {stall_if, stall_id, stall_mem, bubble_ex, flush_ifid, mem_timeout_err, fsm_state};
    assign s_ctl = {s_stall_if, s_stall_id, s_stall_mem, s_bubble_ex, s_flush_ifid, s_err, s_fsm_state};

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_load(ex_load), .ex_WRegEn(ex_WRegEn), .ex_WReg1(ex_WReg1),
        .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
        .stall_if(stall_if), .stall_id(stall_id), .stall_mem(stall_mem),
        .bubble_ex(bubble_ex), .flush_ifid(flush_ifid), .mem_timeout_err(mem_timeout_err),
        .fsm_state(fsm_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
        .CLK(CLK), .RST(RST),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_load(ex_load), .ex_WRegEn(ex_WRegEn), .ex_WReg1(ex_WReg1),
        .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_mem(s_stall_mem),
        .bubble_ex(s_bubble_ex), .flush_ifid(s_flush_ifid), .mem_timeout_err(s_err),
        .fsm_state(s_fsm_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic ld, input logic we,
                                 input logic [4:0] wr, input logic req, input logic ack,
                                 input logic br);
        stim_t s;
        s = {rs1, rs2, u1, u2, ld, we, wr, req, ack, br};
        return s;
    endfunction

    function automatic exp_t ex(input logic [7:0] ctl, input int scnt, input int fcnt);
        exp_t e;
        e = {ctl, 32'(scnt), 32'(fcnt), 1'b0, 8'h00, 32'd0};
        return e;
    endfunction

    function automatic exp_t exs(input logic [7:0] ctl, input int scnt, input int fcnt,
                                 input logic [7:0] sc, input int sscnt);
        exp_t e;
        e = {ctl, 32'(scnt), 32'(fcnt), 1'b1, sc, 32'(sscnt)};
        return e;
    endfunction

    task automatic drive(input stim_t s, input exp_t e);
        {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_load, ex_WRegEn, ex_WReg1,
         mem_req, mem_ack, br_taken} = s;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(C_IDLE, 0, 0));
        void'(sb.pop_back());
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Reset with hazard, memory request and branch all active must leave everything cleared.
    task automatic test_reset();
        exp_t e;
        RST = 1'b1;
        drive(st(5, 0, 1, 0, 1, 1, 5, 1, 0, 1), ex(C_IDLE, 0, 0));
        void'(sb.pop_back());
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), exs(C_IDLE, 0, 0, C_IDLE, 0));
            @(negedge CLK);
            e = sb.pop_front();
            checks += 4;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL reset[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL reset[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            if (flush_cnt !== 16'(e.fcnt)) begin errors++; $display("FAIL reset[%0d] flush_cnt got %0d expected %0d", i, flush_cnt, e.fcnt); end
            if (s_ctl !== e.s_ctl) begin errors++; $display("FAIL reset[%0d] small ctl got %h expected %h", i, s_ctl, e.s_ctl); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t sv[6];
        exp_t  ev[6];
        exp_t  e;
        sv[0] = st(5, 0, 1, 0, 1, 1, 5, 0, 0, 0); ev[0] = ex(C_LU, 0, 0);
        sv[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[1] = ex(C_IDLE, 1, 0);
        sv[2] = st(3, 5, 1, 1, 1, 1, 5, 0, 0, 0); ev[2] = ex(C_LU, 1, 0);
        sv[3] = st(5, 5, 0, 0, 1, 1, 5, 0, 0, 0); ev[3] = ex(C_IDLE, 2, 0);
        sv[4] = st(5, 6, 1, 1, 1, 1, 7, 0, 0, 0); ev[4] = ex(C_IDLE, 2, 0);
        sv[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[5] = ex(C_IDLE, 2, 0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(sv[i], ev[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks += 3;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL load_use[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL load_use[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            if (flush_cnt !== 16'(e.fcnt)) begin errors++; $display("FAIL load_use[%0d] flush_cnt got %0d expected %0d", i, flush_cnt, e.fcnt); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_no_hazard();
        stim_t sv[4];
        exp_t  ev[4];
        exp_t  e;
        sv[0] = st(0, 0, 1, 0, 1, 1, 0, 0, 0, 0); ev[0] = ex(C_IDLE, 0, 0);
        sv[1] = st(5, 0, 1, 0, 1, 0, 5, 0, 0, 0); ev[1] = ex(C_IDLE, 0, 0);
        sv[2] = st(5, 5, 1, 1, 0, 1, 5, 0, 0, 0); ev[2] = ex(C_IDLE, 0, 0);
        sv[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = ex(C_IDLE, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(sv[i], ev[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks += 2;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL no_hazard[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL no_hazard[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t sv[7];
        exp_t  ev[7];
        exp_t  e;
        sv[0] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); ev[0] = exs(C_FRZR, 0, 0, C_FRZR, 0);
        sv[1] = st(5, 0, 1, 0, 1, 1, 5, 1, 0, 0); ev[1] = exs(C_FRZW, 1, 0, C_FRZW, 1);
        sv[2] = st(5, 0, 1, 0, 1, 1, 5, 1, 0, 0); ev[2] = exs(C_FRZW, 2, 0, C_FRZW, 2);
        sv[3] = st(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); ev[3] = exs(C_ACK,  3, 0, C_ACK,  3);
        sv[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[4] = exs(C_IDLE, 3, 0, C_IDLE, 3);
        sv[5] = st(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); ev[5] = exs(C_IDLE, 3, 0, C_IDLE, 3);
        sv[6] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[6] = exs(C_IDLE, 3, 0, C_IDLE, 3);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(sv[i], ev[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks += 4;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL mem_wait[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL mem_wait[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            if (s_ctl !== e.s_ctl) begin errors++; $display("FAIL mem_wait[%0d] small ctl got %h expected %h", i, s_ctl, e.s_ctl); end
            if (s_stall_cnt !== 4'(e.s_scnt)) begin errors++; $display("FAIL mem_wait[%0d] small stall_cnt got %0d expected %0d", i, s_stall_cnt, e.s_scnt); end
            @(posedge CLK); #1;
        end
    endtask

    // dut_s times out after 4 MEM_WAIT cycles; dut keeps waiting.
    task automatic test_timeout();
        exp_t e;
        logic [7:0] sc;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                sc = (i == 0) ? C_FRZR : ((i <= 4) ? C_FRZW : C_ERR);
                drive(st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), exs((i == 0) ? C_FRZR : C_FRZW, i, 0, sc, i));
            end else if (i == 8) begin
                drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), exs(C_FRZW, 8, 0, C_ERR, 8));
            end else begin
                do_reset();
                drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), exs(C_IDLE, 0, 0, C_IDLE, 0));
            end
            @(negedge CLK);
            e = sb.pop_front();
            checks += 5;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL timeout[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL timeout[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            if (s_ctl !== e.s_ctl) begin errors++; $display("FAIL timeout[%0d] small ctl got %h expected %h", i, s_ctl, e.s_ctl); end
            if (s_stall_cnt !== 4'(e.s_scnt)) begin errors++; $display("FAIL timeout[%0d] small stall_cnt got %0d expected %0d", i, s_stall_cnt, e.s_scnt); end
            if (s_flush_cnt !== 4'(e.fcnt)) begin errors++; $display("FAIL timeout[%0d] small flush_cnt got %0d expected %0d", i, s_flush_cnt, e.fcnt); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch();
        stim_t sv[7];
        exp_t  ev[7];
        exp_t  e;
        sv[0] = st(5, 0, 1, 0, 1, 1, 5, 0, 0, 1); ev[0] = ex(C_BR,   0, 0);
        sv[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[1] = ex(C_IDLE, 0, 1);
        sv[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); ev[2] = ex(C_BR,   0, 1);
        sv[3] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); ev[3] = ex(C_FRZR, 0, 2);
        sv[4] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); ev[4] = ex(C_FRZW, 1, 2);
        sv[5] = st(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); ev[5] = ex(C_ACKB, 2, 2);
        sv[6] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[6] = ex(C_IDLE, 2, 3);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(sv[i], ev[i]);
            @(negedge CLK);
            e = sb.pop_front();
            checks += 3;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL branch[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL branch[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            if (flush_cnt !== 16'(e.fcnt)) begin errors++; $display("FAIL branch[%0d] flush_cnt got %0d expected %0d", i, flush_cnt, e.fcnt); end
            @(posedge CLK); #1;
        end
    endtask

    // 20 back-to-back load-use cycles: dut counts to 20, dut_s saturates at 15.
    task automatic test_saturation();
        exp_t e;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i < 20)
                drive(st(5, 0, 1, 0, 1, 1, 5, 0, 0, 0), exs(C_LU, i, 0, C_LU, (i > 15) ? 15 : i));
            else
                drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), exs(C_IDLE, 20, 0, C_IDLE, 15));
            @(negedge CLK);
            e = sb.pop_front();
            checks += 4;
            if (d_ctl !== e.ctl) begin errors++; $display("FAIL saturation[%0d] ctl got %h expected %h", i, d_ctl, e.ctl); end
            if (stall_cnt !== 16'(e.scnt)) begin errors++; $display("FAIL saturation[%0d] stall_cnt got %0d expected %0d", i, stall_cnt, e.scnt); end
            if (s_ctl !== e.s_ctl) begin errors++; $display("FAIL saturation[%0d] small ctl got %h expected %h", i, s_ctl, e.s_ctl); end
            if (s_stall_cnt !== 4'(e.s_scnt)) begin errors++; $display("FAIL saturation[%0d] small stall_cnt got %0d expected %0d", i, s_stall_cnt, e.s_scnt); end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RST = 1'b1;
        {id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_load, ex_WRegEn, ex_WReg1,
         mem_req, mem_ack, br_taken} = '0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_wait();
        test_timeout();
        test_branch();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
